// File: rtl/mc_ram_1p_arb_pkg.sv
// Shared definitions for the MC SRAM arbiter: state encoding and default sizing.
package mc_ram_1p_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } arb_state_t;

    localparam int WORD_WIDTH_DEF    = 20;
    localparam int ADDR_WIDTH_DEF    = 8;
    localparam int MAX_WR_STREAK_DEF = 4;

endpackage

// File: rtl/mc_ram_1p_20x256.sv
// Behavioural 20x256 single-port SRAM macro: active-low enables, 1-cycle read.
module mc_ram_1p_20x256 (
    input  logic        clk,
    input  logic        cen,
    input  logic        oen,
    input  logic        wen,
    input  logic [7:0]  addr,
    input  logic [19:0] din,
    output logic [19:0] dout
);

    logic [19:0] mem [256];
    logic [19:0] q;

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) mem[addr] <= din;
            else      q         <= mem[addr];
        end
    end

    assign dout = oen ? '0 : q;

endmodule

// File: rtl/mc_ram_1p_arb_top.sv
// Optional wrapper binding the arbiter to its physical 20x256 SRAM instance.
module mc_ram_1p_arb_top (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_i,
    output logic        busy_o,
    input  logic        wr_val_i,
    output logic        wr_rdy_o,
    input  logic [7:0]  wr_addr_i,
    input  logic [19:0] wr_dat_i,
    input  logic        rd_val_i,
    output logic        rd_rdy_o,
    input  logic [7:0]  rd_addr_i,
    output logic [19:0] rd_dat_o,
    output logic        rd_dat_val_o
);

    logic        ram_cen, ram_oen, ram_wen;
    logic [7:0]  ram_addr;
    logic [19:0] ram_wdat, ram_rdat;

    mc_ram_1p_arb #(.Word_Width(20), .Addr_Width(8)) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_i       (init_i),
        .busy_o       (busy_o),
        .wr_val_i     (wr_val_i),
        .wr_rdy_o     (wr_rdy_o),
        .wr_addr_i    (wr_addr_i),
        .wr_dat_i     (wr_dat_i),
        .rd_val_i     (rd_val_i),
        .rd_rdy_o     (rd_rdy_o),
        .rd_addr_i    (rd_addr_i),
        .rd_dat_o     (rd_dat_o),
        .rd_dat_val_o (rd_dat_val_o),
        .ram_cen_o    (ram_cen),
        .ram_oen_o    (ram_oen),
        .ram_wen_o    (ram_wen),
        .ram_addr_o   (ram_addr),
        .ram_dat_o    (ram_wdat),
        .ram_dat_i    (ram_rdat)
    );

    mc_ram_1p_20x256 u_ram (
        .clk  (clk),
        .cen  (ram_cen),
        .oen  (ram_oen),
        .wen  (ram_wen),
        .addr (ram_addr),
        .din  (ram_wdat),
        .dout (ram_rdat)
    );

endmodule

// File: rtl/mc_ram_1p_arb.sv
// Arbiter/sequencer sharing one single-port MC SRAM between a write (ref fetch)
// requester and a read (interpolation) requester, plus a self-timed zero-fill.
module mc_ram_1p_arb
    import mc_ram_1p_arb_pkg::*;
#(
    parameter int Word_Width    = WORD_WIDTH_DEF,
    parameter int Addr_Width    = ADDR_WIDTH_DEF,
    parameter int MAX_WR_STREAK = MAX_WR_STREAK_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_i,
    output logic                  busy_o,
    input  logic                  wr_val_i,
    output logic                  wr_rdy_o,
    input  logic [Addr_Width-1:0] wr_addr_i,
    input  logic [Word_Width-1:0] wr_dat_i,
    input  logic                  rd_val_i,
    output logic                  rd_rdy_o,
    input  logic [Addr_Width-1:0] rd_addr_i,
    output logic [Word_Width-1:0] rd_dat_o,
    output logic                  rd_dat_val_o,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [Addr_Width-1:0] ram_addr_o,
    output logic [Word_Width-1:0] ram_dat_o,
    input  logic [Word_Width-1:0] ram_dat_i
);

    localparam int SW = $clog2(MAX_WR_STREAK + 1);

    // Handshake: a requester raises val with stable addr/data and keeps them until
    // it sees rdy in the same cycle; val & rdy at a rising edge is one transfer.
    arb_state_t            state_q, state_d;
    logic [Addr_Width-1:0] init_cnt_q;
    logic [SW-1:0]         streak_q;
    logic                  rd_val_q;
    logic [Word_Width-1:0] hold_q;
    logic                  wr_gnt, rd_gnt;
    logic                  streak_full;

    assign streak_full = (streak_q == SW'(MAX_WR_STREAK));

    // Grants are gated by rst_n so the SRAM is idle for the whole reset window.
    always_comb begin
        state_d    = state_q;
        wr_gnt     = 1'b0;
        rd_gnt     = 1'b0;
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_addr_o = '0;
        ram_dat_o  = '0;
        if (rst_n) begin
            case (state_q)
                ST_IDLE: begin
                    wr_gnt = wr_val_i && !(rd_val_i && streak_full);
                    rd_gnt = rd_val_i && !wr_gnt;
                    if (wr_gnt) begin
                        ram_cen_o  = 1'b0;
                        ram_wen_o  = 1'b0;
                        ram_addr_o = wr_addr_i;
                        ram_dat_o  = wr_dat_i;
                    end else if (rd_gnt) begin
                        ram_cen_o  = 1'b0;
                        ram_addr_o = rd_addr_i;
                    end
                    if (init_i) state_d = ST_INIT;
                end
                ST_INIT: begin
                    ram_cen_o  = 1'b0;
                    ram_wen_o  = 1'b0;
                    ram_addr_o = init_cnt_q;
                    if (init_cnt_q == '1) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
            streak_q   <= '0;
            rd_val_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q  <= state_d;
            rd_val_q <= rd_gnt;
            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
            if (!rd_val_i || rd_gnt) begin
                streak_q <= '0;
            end else if (wr_gnt && !streak_full) begin
                streak_q <= streak_q + SW'(1);
            end
            if (rd_val_q) hold_q <= ram_dat_i;
        end
    end

    assign busy_o       = (state_q == ST_INIT);
    assign wr_rdy_o     = wr_gnt;
    assign rd_rdy_o     = rd_gnt;
    assign rd_dat_val_o = rd_val_q;
    assign rd_dat_o     = rd_val_q ? ram_dat_i : hold_q;
    assign ram_oen_o    = 1'b0;

endmodule

// File: tb/tb_mc_ram_1p_arb.sv
// Randomized self-checking bench for mc_ram_1p_arb with a behavioural SRAM and reference model.
module tb_mc_ram_1p_arb;

    localparam int WW  = 20;
    localparam int AW  = 8;
    localparam int DEP = 256;
    localparam int MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          init_i = 1'b0;
    logic          busy_o;
    logic          wr_val_i = 1'b0;
    logic          wr_rdy_o;
    logic [AW-1:0] wr_addr_i = '0;
    logic [WW-1:0] wr_dat_i = '0;
    logic          rd_val_i = 1'b0;
    logic          rd_rdy_o;
    logic [AW-1:0] rd_addr_i = '0;
    logic [WW-1:0] rd_dat_o;
    logic          rd_dat_val_o;
    logic          ram_cen_o, ram_oen_o, ram_wen_o;
    logic [AW-1:0] ram_addr_o;
    logic [WW-1:0] ram_dat_o;
    logic [WW-1:0] ram_dat_i;

    mc_ram_1p_arb #(.Word_Width(WW), .Addr_Width(AW), .MAX_WR_STREAK(MAX)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_i       (init_i),
        .busy_o       (busy_o),
        .wr_val_i     (wr_val_i),
        .wr_rdy_o     (wr_rdy_o),
        .wr_addr_i    (wr_addr_i),
        .wr_dat_i     (wr_dat_i),
        .rd_val_i     (rd_val_i),
        .rd_rdy_o     (rd_rdy_o),
        .rd_addr_i    (rd_addr_i),
        .rd_dat_o     (rd_dat_o),
        .rd_dat_val_o (rd_dat_val_o),
        .ram_cen_o    (ram_cen_o),
        .ram_oen_o    (ram_oen_o),
        .ram_wen_o    (ram_wen_o),
        .ram_addr_o   (ram_addr_o),
        .ram_dat_o    (ram_dat_o),
        .ram_dat_i    (ram_dat_i)
    );

    // Behavioural SRAM attached to the DUT's memory port.
    logic [WW-1:0] sram [DEP];
    logic [WW-1:0] sram_q = '0;
    always @(posedge clk) begin
        if (!ram_cen_o) begin
            if (!ram_wen_o) sram[ram_addr_o] <= ram_dat_o;
            else            sram_q <= sram[ram_addr_o];
        end
    end
    assign ram_dat_i = sram_q;

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: contents, pending init cycles, write streak, read return queue.
    logic [WW-1:0] m_mem [DEP];
    int            m_init_left = 0;
    int            m_streak = 0;
    logic          m_rd_pend = 1'b0;
    logic [WW-1:0] m_hold = '0;
    logic [WW-1:0] exp_q[$];
    logic          wr_fire = 1'b0;
    logic          rd_fire = 1'b0;
    logic [WW-1:0] e_dat;
    logic [AW-1:0] e_addr;
    logic          e_w, e_r;

    always @(negedge clk) begin
        wr_fire = wr_val_i && wr_rdy_o;
        rd_fire = rd_val_i && rd_rdy_o;
        if (!rst_n) begin
            m_init_left = 0;
            m_streak    = 0;
            m_rd_pend   = 1'b0;
            m_hold      = '0;
            exp_q.delete();
            check("rst_busy", 32'(busy_o), 0);
            check("rst_dval", 32'(rd_dat_val_o), 0);
            check("rst_dat", 32'(rd_dat_o), 0);
            check("rst_cen", 32'(ram_cen_o), 1);
            check("rst_wen", 32'(ram_wen_o), 1);
            check("rst_oen", 32'(ram_oen_o), 0);
            check("rst_rdy", 32'({wr_rdy_o, rd_rdy_o}), 0);
        end else begin
            if (m_rd_pend) begin
                e_dat = exp_q.pop_front();
                m_hold = e_dat;
                check("rd_strobe", 32'(rd_dat_val_o), 1);
                check("rd_data", 32'(rd_dat_o), 32'(e_dat));
            end else begin
                check("rd_nostrobe", 32'(rd_dat_val_o), 0);
                check("rd_hold", 32'(rd_dat_o), 32'(m_hold));
            end
            m_rd_pend = 1'b0;
            check("busy", 32'(busy_o), 32'(m_init_left > 0));
            check("oen", 32'(ram_oen_o), 0);
            if (m_init_left > 0) begin
                e_addr = AW'(DEP - m_init_left);
                check("init_rdy", 32'({wr_rdy_o, rd_rdy_o}), 0);
                check("init_cen", 32'(ram_cen_o), 0);
                check("init_wen", 32'(ram_wen_o), 0);
                check("init_addr", 32'(ram_addr_o), 32'(e_addr));
                check("init_wdat", 32'(ram_dat_o), 0);
                m_mem[e_addr] = '0;
                m_init_left--;
                if (!rd_val_i) m_streak = 0;
            end else begin
                e_w = wr_val_i && !(rd_val_i && m_streak == MAX);
                e_r = rd_val_i && !e_w;
                check("wr_rdy", 32'(wr_rdy_o), 32'(e_w));
                check("rd_rdy", 32'(rd_rdy_o), 32'(e_r));
                if (e_w) begin
                    check("w_cen", 32'(ram_cen_o), 0);
                    check("w_wen", 32'(ram_wen_o), 0);
                    check("w_addr", 32'(ram_addr_o), 32'(wr_addr_i));
                    check("w_dat", 32'(ram_dat_o), 32'(wr_dat_i));
                    m_mem[wr_addr_i] = wr_dat_i;
                end else if (e_r) begin
                    check("r_cen", 32'(ram_cen_o), 0);
                    check("r_wen", 32'(ram_wen_o), 1);
                    check("r_addr", 32'(ram_addr_o), 32'(rd_addr_i));
                    check("r_wdat", 32'(ram_dat_o), 0);
                    exp_q.push_back(m_mem[rd_addr_i]);
                    m_rd_pend = 1'b1;
                end else begin
                    check("idle_cen", 32'(ram_cen_o), 1);
                    check("idle_wdat", 32'(ram_dat_o), 0);
                end
                if (!rd_val_i || e_r)             m_streak = 0;
                else if (e_w && m_streak < MAX)   m_streak++;
                if (init_i) m_init_left = DEP;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_busy_len(output int n);
        n = 0;
        while (busy_o && n < 400) begin
            n++;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_init();
        int n;
        @(posedge clk); #1 init_i = 1'b1;
        @(posedge clk); #1 init_i = 1'b0;
        #1;
        wait_busy_len(n);
        check("busy_len", 32'(n), 32'(DEP));
    endtask

    task automatic wr_one(input logic [AW-1:0] a, input logic [WW-1:0] d);
        @(posedge clk); #1 wr_val_i = 1'b1; wr_addr_i = a; wr_dat_i = d;
        @(posedge clk); #1 wr_val_i = 1'b0;
    endtask

    task automatic rd_one(input logic [AW-1:0] a, input logic [WW-1:0] exp);
        @(posedge clk); #1 rd_val_i = 1'b1; rd_addr_i = a;
        #1 check("rd_one_rdy", 32'(rd_rdy_o), 1);
        @(posedge clk); #1 rd_val_i = 1'b0;
        #1 check("rd_one_val", 32'(rd_dat_val_o), 1);
        check("rd_one_dat", 32'(rd_dat_o), 32'(exp));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        for (int i = 0; i < DEP; i++) begin
            sram[i]  = WW'($urandom);
            m_mem[i] = sram[i];
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // zero-fill, then a read from the middle returns zero
        do_init();
        rd_one(8'h7F, 20'h0);

        // write then read with hold over idle cycles
        wr_one(8'h10, 20'hABCDE);
        rd_one(8'h10, 20'hABCDE);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #2;
            check("hold_idle", 32'(rd_dat_o), 32'h000ABCDE);
        end

        // both requesters saturated: W,W,W,W,R pattern
        @(posedge clk); #1 wr_val_i = 1'b1; rd_val_i = 1'b1;
        wr_addr_i = 8'h40; wr_dat_i = 20'h12345; rd_addr_i = 8'h41;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("pat_rd", 32'(rd_rdy_o), 32'(i % 5 == 4));
            check("pat_wr", 32'(wr_rdy_o), 32'(i % 5 != 4));
            @(posedge clk); #1;
        end
        wr_val_i = 1'b0; rd_val_i = 1'b0;

        // back-to-back reads
        wr_one(8'h01, 20'h1);
        wr_one(8'h02, 20'h2);
        wr_one(8'h03, 20'h3);
        @(posedge clk); #1 rd_val_i = 1'b1; rd_addr_i = 8'h01;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            if (i < 3) rd_addr_i = AW'(i + 1);
            else       rd_val_i = 1'b0;
            #1;
            check("b2b_val", 32'(rd_dat_val_o), 1);
            check("b2b_dat", 32'(rd_dat_o), 32'(i));
        end
        @(posedge clk); #2 check("b2b_end", 32'(rd_dat_val_o), 0);

        // requests held across INIT, second init pulse ignored
        @(posedge clk); #1 init_i = 1'b1;
        @(posedge clk); #1 init_i = 1'b0;
        wr_val_i = 1'b1; wr_addr_i = 8'h20; wr_dat_i = 20'h5A5A5;
        rd_val_i = 1'b1; rd_addr_i = 8'h20;
        #1;
        n = 0;
        while (busy_o && n < 400) begin
            n++;
            if (n == 100) init_i = 1'b1;
            if (n == 101) init_i = 1'b0;
            @(posedge clk); #2;
        end
        check("held_busy_len", 32'(n), 32'(DEP));
        check("held_wr_first", 32'(wr_rdy_o), 1);
        check("held_rd_first", 32'(rd_rdy_o), 0);
        @(posedge clk); #1 wr_val_i = 1'b0;
        #1 check("held_rd_next", 32'(rd_rdy_o), 1);
        @(posedge clk); #1 rd_val_i = 1'b0;

        // randomized traffic with occasional init pulses
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (!(wr_val_i && !wr_fire)) begin
                wr_val_i  = 1'($urandom_range(0, 1));
                wr_addr_i = AW'($urandom_range(0, 15));
                wr_dat_i  = WW'($urandom);
            end
            if (!(rd_val_i && !rd_fire)) begin
                rd_val_i  = 1'($urandom_range(0, 1));
                rd_addr_i = AW'($urandom_range(0, 15));
            end
            init_i = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1 wr_val_i = 1'b0; rd_val_i = 1'b0; init_i = 1'b0;
        n = 0;
        while (busy_o && n < 400) begin
            n++;
            @(posedge clk); #1;
        end
        check("rand_drain", 32'(busy_o), 0);

        // reset in the middle of INIT
        @(posedge clk); #1 init_i = 1'b1;
        @(posedge clk); #1 init_i = 1'b0; rd_val_i = 1'b1; rd_addr_i = 8'h05;
        repeat (99) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o), 0);
        check("arst_cen", 32'(ram_cen_o), 1);
        check("arst_rdy", 32'(rd_rdy_o), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("post_rst_rd", 32'(rd_rdy_o), 1);
        check("post_rst_addr", 32'(ram_addr_o), 32'h05);
        @(posedge clk); #1 rd_val_i = 1'b0;
        do_init();
        rd_one(8'hFF, 20'h0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
